// File: rtl/exp_diff_arbiter.sv
// Round-robin arbiter sharing one pipelined exponent-difference unit among NUM_REQ lanes.
// Define EXP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module exp_diff_arbiter #(
  parameter int SIZE_EXP = 8,
  parameter int NUM_REQ  = 4,
  parameter int LATENCY  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [NUM_REQ*SIZE_EXP-1:0]  i_req_exp_a,
  input  logic [NUM_REQ*SIZE_EXP-1:0]  i_req_exp_b,
  output logic [SIZE_EXP-1:0]          o_unit_exp_a,
  output logic [SIZE_EXP-1:0]          o_unit_exp_b,
  input  logic [SIZE_EXP-1:0]          i_unit_exp_greater,
  input  logic [SIZE_EXP-1:0]          i_unit_diff_value,
  input  logic                         i_unit_diff_signal,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic [SIZE_EXP-1:0]          o_rsp_exp_greater,
  output logic [SIZE_EXP-1:0]          o_rsp_diff_value,
  output logic                         o_rsp_diff_signal,
  output logic                         o_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = PTR_W + 1;

  logic [PTR_W-1:0] w_start;
  logic [CW-1:0]    w_cand;
  logic             w_found;
  logic [PTR_W-1:0] w_gnt_idx;
  logic             w_accept;
  logic             w_rsp_on;

  logic [LATENCY-1:0] r_tag_vld;
  logic [PTR_W-1:0]   r_tag_id [LATENCY];

`ifdef EXP_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [CW-1:0]    w_inc;

  // Next pointer is the lane after the granted one, wrapping modulo NUM_REQ.
  always_comb begin
    w_inc = {1'b0, w_gnt_idx} + CW'(1);
    if (w_inc >= CW'(NUM_REQ)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_inc[PTR_W-1:0];
    end
  end

  // Priority pointer moves only on an accepted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_start = r_ptr;
`endif

  // Search for the first valid lane starting at the pointer, with wrap-around.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, w_start} + CW'(i);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end else begin
        w_cand = w_cand;
      end
      if (!w_found && i_req_valid[w_cand[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[PTR_W-1:0];
      end else begin
        w_found   = w_found;
      end
    end
  end

  // Reset gating keeps ready and unit operands at zero while reset is held.
  assign w_accept = w_found & ~i_flush & i_rst_n;

  // One-hot ready and granted operands to the shared unit.
  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_req_ready[i] = w_accept && (w_gnt_idx == PTR_W'(i));
    end
    if (w_accept) begin
      o_unit_exp_a = i_req_exp_a[w_gnt_idx*SIZE_EXP +: SIZE_EXP];
      o_unit_exp_b = i_req_exp_b[w_gnt_idx*SIZE_EXP +: SIZE_EXP];
    end else begin
      o_unit_exp_a = '0;
      o_unit_exp_b = '0;
    end
  end

  // Tag pipeline mirrors the unit depth; flush drops every in-flight tag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_tag_id[k] <= '0;
      end
    end else if (i_flush) begin
      r_tag_vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_accept;
      r_tag_id[0]  <= w_accept ? w_gnt_idx : '0;
      for (int k = 1; k < LATENCY; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  // A result presented in the same cycle as a flush is killed along with the rest.
  assign w_rsp_on = r_tag_vld[LATENCY-1] & ~i_flush;

  // Route the unit result to the lane named by the oldest tag.
  always_comb begin
    o_rsp_valid = '0;
    if (w_rsp_on) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        o_rsp_valid[i] = (r_tag_id[LATENCY-1] == PTR_W'(i));
      end
      o_rsp_exp_greater = i_unit_exp_greater;
      o_rsp_diff_value  = i_unit_diff_value;
      o_rsp_diff_signal = i_unit_diff_signal;
    end else begin
      o_rsp_exp_greater = '0;
      o_rsp_diff_value  = '0;
      o_rsp_diff_signal = 1'b0;
    end
  end

  assign o_busy = |r_tag_vld;

endmodule

// File: tb/tb_exp_diff_arbiter.sv
// Self-checking bench for exp_diff_arbiter: directed table, corner sequences, random traffic.
module tb_exp_diff_arbiter;
  localparam int SE  = 8;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*SE-1:0] req_a;
  logic [N*SE-1:0] req_b;
  logic [SE-1:0]   unit_a, unit_b, u_greater, u_diff;
  logic            u_sig;
  logic [N-1:0]    rsp_valid;
  logic [SE-1:0]   rsp_greater, rsp_diff;
  logic            rsp_sig;
  logic            busy;

  exp_diff_arbiter #(.SIZE_EXP(SE), .NUM_REQ(N), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_exp_a(req_a), .i_req_exp_b(req_b),
    .o_unit_exp_a(unit_a), .o_unit_exp_b(unit_b),
    .i_unit_exp_greater(u_greater), .i_unit_diff_value(u_diff), .i_unit_diff_signal(u_sig),
    .o_rsp_valid(rsp_valid), .o_rsp_exp_greater(rsp_greater),
    .o_rsp_diff_value(rsp_diff), .o_rsp_diff_signal(rsp_sig),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Shared unit model: LAT-deep pipeline, samples operands every edge.
  logic [SE-1:0] ua_p [LAT] = '{default: '0};
  logic [SE-1:0] ub_p [LAT] = '{default: '0};
  always @(posedge clk) begin
    ua_p[0] <= unit_a;
    ub_p[0] <= unit_b;
    for (int k = 1; k < LAT; k++) begin
      ua_p[k] <= ua_p[k-1];
      ub_p[k] <= ub_p[k-1];
    end
  end
  assign u_greater = (ua_p[LAT-1] >= ub_p[LAT-1]) ? ua_p[LAT-1] : ub_p[LAT-1];
  assign u_diff    = (ua_p[LAT-1] >= ub_p[LAT-1]) ? ua_p[LAT-1] - ub_p[LAT-1] : ub_p[LAT-1] - ua_p[LAT-1];
  assign u_sig     = (ua_p[LAT-1] < ub_p[LAT-1]);

  typedef struct { int due; int lane; logic [SE-1:0] a; logic [SE-1:0] b; } inflight_t;
  typedef struct { int lane; logic [SE-1:0] a; logic [SE-1:0] b;
                   logic [SE-1:0] g; logic [SE-1:0] d; logic s; } vec_t;

  inflight_t     q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            ptr_m = 0;
  int            last_g = -1;
  logic [N-1:0]  pend = '0;
  logic [SE-1:0] la [N] = '{default: '0};
  logic [SE-1:0] lb [N] = '{default: '0};
  logic          flush_b = 1'b0;
  logic [N-1:0]  seen_v;
  logic [SE-1:0] seen_g, seen_d;
  logic          seen_s;
  vec_t          tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive lanes, compare against the reference model, then advance.
  task automatic step();
    int            g;
    logic          busy_e;
    logic [N-1:0]  rv_e;
    logic [SE-1:0] g_e, d_e, ua_e, ub_e;
    logic          s_e;
    inflight_t     e;
    req_valid = pend;
    flush     = flush_b;
    for (int l = 0; l < N; l++) begin
      req_a[l*SE +: SE] = la[l];
      req_b[l*SE +: SE] = lb[l];
    end
    @(negedge clk);
    g = -1;
    if (!flush_b) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && pend[(ptr_m + i) % N]) g = (ptr_m + i) % N;
      end
    end
    ua_e = '0; ub_e = '0;
    if (g >= 0) begin
      ua_e = la[g];
      ub_e = lb[g];
    end
    chk("ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("unit_a", 32'(unit_a), 32'(ua_e));
    chk("unit_b", 32'(unit_b), 32'(ub_e));
    busy_e = 1'b0;
    foreach (q[j]) begin
      if (cyc >= q[j].due - LAT + 1 && cyc <= q[j].due) busy_e = 1'b1;
    end
    chk("busy", 32'(busy), 32'(busy_e));
    if (flush_b) q.delete();
    rv_e = '0; g_e = '0; d_e = '0; s_e = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      rv_e[e.lane] = 1'b1;
      g_e = (e.a >= e.b) ? e.a : e.b;
      d_e = (e.a >= e.b) ? e.a - e.b : e.b - e.a;
      s_e = (e.a < e.b);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(rv_e));
    chk("rsp_greater", 32'(rsp_greater), 32'(g_e));
    chk("rsp_diff", 32'(rsp_diff), 32'(d_e));
    chk("rsp_signal", 32'(rsp_sig), 32'(s_e));
    if (rsp_valid != '0) begin
      seen_v = rsp_valid; seen_g = rsp_greater; seen_d = rsp_diff; seen_s = rsp_sig;
    end
    last_g = g;
    @(posedge clk);
    if (g >= 0) begin
      pend[g] = 1'b0;
      ptr_m   = (g + 1) % N;
      e.due = cyc + LAT; e.lane = g; e.a = la[g]; e.b = lb[g];
      q.push_back(e);
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < LAT + 2; k++) step();
  endtask

  task automatic arm(input int l);
    pend[l] = 1'b1;
    la[l]   = SE'($urandom);
    lb[l]   = ($urandom_range(0, 7) == 0) ? la[l] : SE'($urandom);
  endtask

  initial begin
    tbl[0] = '{1, 8'h85, 8'h80, 8'h85, 8'h05, 1'b0};
    tbl[1] = '{0, 8'h7F, 8'h82, 8'h82, 8'h03, 1'b1};
    tbl[2] = '{2, 8'h90, 8'h90, 8'h90, 8'h00, 1'b0};
    tbl[3] = '{3, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1};
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    #7;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_unit_a", 32'(unit_a), 32'd0);
    chk("reset_rsp_greater", 32'(rsp_greater), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fairness: all lanes valid continuously from reset.
    for (int l = 0; l < N; l++) arm(l);
    for (int i = 0; i < 2 * N; i++) begin
      step();
      chk("rr_grant", last_g, i % N);
      if (last_g >= 0) arm(last_g);
    end
    pend = '0;
    drain();

    // Directed single-request vectors.
    foreach (tbl[v]) begin
      pend[tbl[v].lane] = 1'b1;
      la[tbl[v].lane] = tbl[v].a;
      lb[tbl[v].lane] = tbl[v].b;
      step();
      chk("tbl_grant", last_g, tbl[v].lane);
      seen_v = '0;
      for (int k = 0; k < LAT; k++) step();
      chk("tbl_rsp_valid", 32'(seen_v), 32'd1 << tbl[v].lane);
      chk("tbl_greater", 32'(seen_g), 32'(tbl[v].g));
      chk("tbl_diff", 32'(seen_d), 32'(tbl[v].d));
      chk("tbl_signal", 32'(seen_s), 32'(tbl[v].s));
      drain();
    end

    // Pointer hold across an idle cycle.
    arm(0);
    step();
    chk("hold_grant0", last_g, 0);
    step();
    arm(2); arm(3);
    step();
    chk("hold_grant2", last_g, 2);
    step();
    chk("hold_grant3", last_g, 3);
    drain();

    // Flush with two operations in flight and a third lane waiting.
    arm(1); arm(2);
    step();
    step();
    arm(0);
    flush_b = 1'b1;
    step();
    chk("flush_grant", last_g, -1);
    flush_b = 1'b0;
    seen_v = '0;
    step();
    chk("post_flush_grant", last_g, 0);
    drain();
    chk("post_flush_rsp", 32'(seen_v), 32'd1);

    // Asynchronous reset with a request in flight.
    arm(1);
    step();
    for (int l = 0; l < N; l++) arm(l);
    req_valid = pend;
    for (int l = 0; l < N; l++) begin
      req_a[l*SE +: SE] = la[l];
      req_b[l*SE +: SE] = lb[l];
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_unit_a", 32'(unit_a), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_diff", 32'(rsp_diff), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    q.delete();
    ptr_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    step();
    chk("rst_first_grant", last_g, 0);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < N; l++) begin
        if (!pend[l] && $urandom_range(0, 1) == 1) arm(l);
      end
      flush_b = ($urandom_range(0, 24) == 0);
      step();
    end
    flush_b = 1'b0;
    pend = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
